// File: rtl/cla_serial_adder_pkg.sv
// cla_defs: shared group width and FSM encoding for the digit-serial CLA adder
package cla_defs;
  localparam int GROUP_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit two-level carry-lookahead slice
module cla_group4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);
  logic [3:0] g, p;
  logic       c1, c2;
  assign g  = x & y;
  assign p  = x | y;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = x ^ y ^ {c3, c2, c1, ci};
endmodule

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: digit-serial adder/subtractor, one 4-bit CLA group per clock
module cla_serial_adder
  import cla_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / GROUP_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t            state;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  wa, wb, wr, wr_nxt;
  logic              carry, c3, co, last;
  logic [GROUP_W-1:0] s;
  cla_group4 u_slice (
    .x (wa[GROUP_W*idx +: GROUP_W]),
    .y (wb[GROUP_W*idx +: GROUP_W]),
    .ci(carry),
    .s (s),
    .c3(c3),
    .co(co)
  );
  assign last = idx == IW'(N - 1);
  // Merge the current slice into the working result so the final edge can publish it whole
  always_comb begin
    wr_nxt = wr;
    wr_nxt[GROUP_W*idx +: GROUP_W] = s;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      wa    <= '0;
      wb    <= '0;
      wr    <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      wr    <= wr_nxt;
      carry <= co;
      idx   <= idx + 1'b1;
      if (last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        sum   <= wr_nxt;
        cout  <= co;
        ovf   <= c3 ^ co;
      end
    end else begin
      done  <= 1'b0;
      busy  <= start;
      state <= start ? RUN : IDLE;
      if (start) begin
        wa    <= a;
        wb    <= b ^ {WIDTH{sub}};
        carry <= cin ^ sub;
        idx   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: directed checks of the 16-bit digit-serial CLA adder
module tb_cla_serial_adder;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  int          passed = 0, total = 0;

  cla_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // Issue one op from #1 after an edge; done must appear 5 edges after (and including) the start edge
  task automatic go(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                    input logic tc, input logic ts, input logic poke,
                    input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] prev;
    int n;
    bit held;
    prev = sum;
    held = 1;
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    chk({tag, ".busy"}, busy, 1);
    while (!done && n < 20) begin
      if (poke && n == 2) begin start = 1'b1; a = 16'hAAAA; b = 16'h5555; end
      if (poke && n == 3) start = 1'b0;
      held &= (sum == prev);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, 5);
    chk({tag, ".hold"}, held, 1);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  initial begin
    a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b1; start = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 16'h0000);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    go("add", 16'h1234, 16'h4321, 0, 0, 0, 16'h5555, 0, 0);
    go("ripple", 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0);
    go("ripcin", 16'hFFFF, 16'h0000, 1, 0, 0, 16'h0000, 1, 0);
    go("subovf", 16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1);
    go("subneg", 16'h0003, 16'h0005, 0, 1, 0, 16'hFFFE, 0, 0);
    @(posedge clk); #1;
    chk("idle.done", done, 0);

    go("poke", 16'h1111, 16'h2222, 0, 0, 1, 16'h3333, 0, 0);
    go("b2b", 16'h0100, 16'h0200, 0, 0, 0, 16'h0300, 0, 0);

    a = 16'h7777; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.sum", sum, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("mid.nodone", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    go("after", 16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Digit-serial, parametrised carry-lookahead adder/subtractor. Each clock it computes one 4-bit carry-lookahead group, so a WIDTH-bit operation takes WIDTH/4 compute cycles. It reuses a single 4-bit CLA slice instead of replicating lookahead logic across the full width. It is the area-optimised arithmetic unit for wide operands in the lab datapath, driven by a start/done handshake from a controlling FSM.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 groups.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0 or done=1.
- sub  in  1  0: add; 1: subtract. Sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) or borrow-in (sub), sampled with start.
- busy  out  1  high from the edge accepting start until done.
- done  out  1  one-cycle pulse; the result outputs are valid from this cycle on.
- sum  out  WIDTH  registered result; held until the next completion.
- cout  out  1  carry out of the MSB. In sub mode this is the not-borrow.
- ovf  out  1  signed overflow: carry into MSB xor carry out of MSB.

## Operation
- Add: result = a + b + cin.
- Sub: result = a + ~b + ~cin, i.e. a − b − cin in two's complement.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, group index idx runs from 0 to N−1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→RUN while idx<N−1; RUN→DONE when idx=N−1 is processed.
  - DONE→RUN on start (back-to-back), otherwise DONE→IDLE.
- Accepting start captures:
  - a into the working register.
  - b xor {WIDTH{sub}} into the working register.
  - cin xor sub as the running carry.
  - idx=0.
- In RUN, each cycle:
  - Feed a[4idx+3:4idx], b'[4idx+3:4idx] and the running carry to the CLA slice.
  - Write the slice sum into working result bits [4idx+3:4idx].
  - Register the slice carry-out as the running carry; increment idx.
- On the final group, also register slice c3 (carry into the MSB) and the carry-out.
- On the RUN→DONE edge, copy the working result to sum, set cout to the final carry and ovf to c3 xor the final carry.
- sum/cout/ovf change only on the RUN→DONE edge or on reset. They are never partially updated.
- start while in RUN is ignored and has no side effects.
- WIDTH=4 (N=1): RUN lasts one cycle.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, idx=0, all working registers 0.
- rst asserted at any time, including mid-RUN:
  - Immediate return to reset values.
  - No done pulse; the operation is discarded.
- Latency: start sampled at edge E0 → busy=1 after E0 → result registered at edge EN → done=1 for the cycle after EN. The start→done latency is N+1 edges.
- Throughput: one operation per N+1 cycles, sustained via start during DONE.
- The slice is purely combinational. Its critical path is one 4-bit CLA, independent of WIDTH.

## Structure
- Shared include/package cla_defs: GROUP_W = 4, state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, cla_group4: inputs x[3:0], y[3:0], ci; outputs s[3:0], c3 (carry into bit 3), co.
  - Per-bit G = x&y, P = x|y.
  - Full two-level lookahead equations for c1, c2, c3, co.
  - Sum bits are x^y^carry.
- Top level holds the FSM, idx counter (width clog2(N), minimum 1), working registers and output registers.

## Test plan
All scenarios use WIDTH=16.
- Reset: assert rst with random inputs → busy=0, done=0, sum=0x0000, cout=0, ovf=0.
- Add, no carry: a=0x1234, b=0x4321, cin=0, sub=0 → done exactly 5 edges after the start edge, sum=0x5555, cout=0, ovf=0.
- Full-width carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. With cin=1 and b=0x0000 → same result.
- Subtract with overflow: a=0x8000, b=0x0001, sub=1, cin=0 → sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005 → sum=0xFFFE, cout=0, ovf=0.
- Handshake:
  - start pulsed during RUN → ignored; result matches the first operands.
  - start held in the DONE cycle → new op accepted; second done arrives 5 edges later.
  - sum holds its previous value throughout the second RUN.
- Reset mid-RUN: rst at idx=2 → outputs at reset values at once, no done. The next op (0x00FF+0x0001) → sum=0x0100.
